// File: rtl/pipe_ctrl_defs.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// default divide latency, stage indices and the load-use match helper.
package pipe_ctrl_defs;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DIV_BUSY = 2'd1;
    localparam logic [1:0] ST_EXC_PEND = 2'd2;

    localparam int DIV_CYCLES_DEF = 36;

    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;
    localparam int STG_M = 3;
    localparam int STG_W = 4;

    // $zero is never a real producer, so a load targeting it cannot create a hazard.
    function automatic logic load_use_hit(
        input logic       memtoreg,
        input logic       regwrite,
        input logic [4:0] wreg,
        input logic [4:0] rs,
        input logic [4:0] rt
    );
        return memtoreg && regwrite && (wreg != 5'd0) && ((wreg == rs) || (wreg == rt));
    endfunction

endpackage

// File: rtl/div_busy_timer.sv
// Divider occupancy timer: loads DIV_CYCLES-1, counts down to zero and stops;
// o_last marks the final occupied cycle.
module div_busy_timer #(
    parameter int DIV_CYCLES = 36
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_load,
    input  logic i_clear,
    output logic o_busy,
    output logic o_last
);

    localparam int CW = $clog2(DIV_CYCLES);

    logic [CW-1:0] r_cnt;
    logic          r_run;

    always_ff @(posedge clk) begin
        if (!resetn || i_clear) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= CW'(DIV_CYCLES - 1);
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0)
                r_run <= 1'b0;
            else
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = r_run;
    assign o_last = r_run && (r_cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Optional performance counters
// are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import pipe_ctrl_defs::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  writeregE,
    input  logic        regwriteE,
    input  logic        memtoregE,
    input  logic        div_startE,
    input  logic        branch_mispredE,
    input  logic        flush_excM,
    input  logic        i_stall,
    input  logic        d_stall,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        stallW,
    output logic        flushF,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        div_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_load_use,
    output logic [31:0] perf_div_stall,
    output logic [31:0] perf_mem_stall
`endif
);

    logic [1:0] r_state;
    logic [1:0] w_nxt;
    logic [4:0] w_stall;
    logic [4:0] w_flush;
    logic       w_tmr_busy;
    logic       w_tmr_last;
    logic       w_div;
    logic       w_lu;
    logic       w_div_start;

    assign w_div_start = (r_state == ST_IDLE) && div_startE && !d_stall && !flush_excM;
    assign w_div       = (r_state == ST_DIV_BUSY) && w_tmr_busy;
    assign w_lu        = load_use_hit(memtoregE, regwriteE, writeregE, rsD, rtD);

    div_busy_timer #(.DIV_CYCLES(DIV_CYCLES)) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_div_start),
        .i_clear (flush_excM),
        .o_busy  (w_tmr_busy),
        .o_last  (w_tmr_last)
    );

    always_comb begin
        w_nxt = r_state;
        if (flush_excM) begin
            w_nxt = d_stall ? ST_EXC_PEND : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (w_div_start) w_nxt = ST_DIV_BUSY;
                ST_DIV_BUSY: if (w_tmr_last)  w_nxt = ST_IDLE;
                ST_EXC_PEND: if (!d_stall)    w_nxt = ST_IDLE;
                default:     w_nxt = ST_IDLE;
            endcase
        end
    end

    // A deferred exception behaves like a memory stall until the D-cache releases.
    always_comb begin
        w_stall = '0;
        w_flush = '0;
        if (flush_excM || (r_state == ST_EXC_PEND)) begin
            if (d_stall) begin
                w_stall[STG_M:STG_F] = 4'b1111;
                w_flush[STG_W]       = 1'b1;
            end else begin
                w_flush[STG_M:STG_F] = 4'b1111;
            end
        end else if (d_stall) begin
            w_stall[STG_M:STG_F] = 4'b1111;
            w_flush[STG_W]       = 1'b1;
        end else if (w_div) begin
            w_stall[STG_E:STG_F] = 3'b111;
            w_flush[STG_M]       = 1'b1;
        end else if (i_stall) begin
            w_stall[STG_F] = 1'b1;
            w_flush[STG_D] = 1'b1;
        end else if (branch_mispredE) begin
            w_flush[STG_D] = 1'b1;
        end else if (w_lu) begin
            w_stall[STG_D:STG_F] = 2'b11;
            w_flush[STG_E]       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_nxt;
    end

    assign stallF   = resetn && w_stall[STG_F];
    assign stallD   = resetn && w_stall[STG_D];
    assign stallE   = resetn && w_stall[STG_E];
    assign stallM   = resetn && w_stall[STG_M];
    assign stallW   = resetn && w_stall[STG_W];
    assign flushF   = resetn && w_flush[STG_F];
    assign flushD   = resetn && w_flush[STG_D];
    assign flushE   = resetn && w_flush[STG_E];
    assign flushM   = resetn && w_flush[STG_M];
    assign flushW   = resetn && w_flush[STG_W];
    assign div_busy = resetn && (r_state == ST_DIV_BUSY);

`ifdef HAZARD_PERF_CNT_EN
    logic        w_src_mem;
    logic        w_src_div;
    logic        w_src_lu;
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_div;
    logic [31:0] r_perf_mem;

    assign w_src_mem = !flush_excM && (r_state != ST_EXC_PEND) && d_stall;
    assign w_src_div = !flush_excM && (r_state != ST_EXC_PEND) && !d_stall && w_div;
    assign w_src_lu  = !flush_excM && (r_state != ST_EXC_PEND) && !d_stall && !w_div
                       && !i_stall && !branch_mispredE && w_lu;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_perf_lu  <= '0;
            r_perf_div <= '0;
            r_perf_mem <= '0;
        end else begin
            r_perf_lu  <= r_perf_lu  + {31'd0, w_src_lu};
            r_perf_div <= r_perf_div + {31'd0, w_src_div};
            r_perf_mem <= r_perf_mem + {31'd0, w_src_mem};
        end
    end

    assign perf_load_use  = r_perf_lu;
    assign perf_div_stall = r_perf_div;
    assign perf_mem_stall = r_perf_mem;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; outputs are sampled 2 time units after
// the rising edge as {stallF..stallW, flushF..flushW, div_busy}.
module tb_hazard_ctrl;

    localparam logic [10:0] P_NONE = 11'b00000_00000_0;
    localparam logic [10:0] P_LU   = 11'b11000_00100_0;
    localparam logic [10:0] P_DIV  = 11'b11100_00010_1;
    localparam logic [10:0] P_DST  = 11'b11110_00001_0;
    localparam logic [10:0] P_DSTB = 11'b11110_00001_1;
    localparam logic [10:0] P_IST  = 11'b10000_01000_0;
    localparam logic [10:0] P_MISP = 11'b00000_01000_0;
    localparam logic [10:0] P_EXC  = 11'b00000_11110_0;
    localparam logic [10:0] P_EXCB = 11'b00000_11110_1;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] rsD, rtD, writeregE;
    logic       regwriteE, memtoregE, div_startE, branch_mispredE, flush_excM;
    logic       i_stall, d_stall;
    logic       stallF, stallD, stallE, stallM, stallW;
    logic       flushF, flushD, flushE, flushM, flushW, div_busy;
    logic [10:0] outs;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_load_use, perf_div_stall, perf_mem_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign outs = {stallF, stallD, stallE, stallM, stallW,
                   flushF, flushD, flushE, flushM, flushW, div_busy};

    hazard_ctrl dut (
        .clk             (clk),
        .resetn          (resetn),
        .rsD             (rsD),
        .rtD             (rtD),
        .writeregE       (writeregE),
        .regwriteE       (regwriteE),
        .memtoregE       (memtoregE),
        .div_startE      (div_startE),
        .branch_mispredE (branch_mispredE),
        .flush_excM      (flush_excM),
        .i_stall         (i_stall),
        .d_stall         (d_stall),
        .stallF          (stallF),
        .stallD          (stallD),
        .stallE          (stallE),
        .stallM          (stallM),
        .stallW          (stallW),
        .flushF          (flushF),
        .flushD          (flushD),
        .flushE          (flushE),
        .flushM          (flushM),
        .flushW          (flushW),
        .div_busy        (div_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_load_use   (perf_load_use),
        .perf_div_stall  (perf_div_stall),
        .perf_mem_stall  (perf_mem_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsD = 5'd0; rtD = 5'd0; writeregE = 5'd0;
        regwriteE = 1'b0; memtoregE = 1'b0; div_startE = 1'b0;
        branch_mispredE = 1'b0; flush_excM = 1'b0; i_stall = 1'b0; d_stall = 1'b0;
    endtask

    task automatic set_lw_hit();
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd8; rsD = 5'd8; rtD = 5'd3;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        d_stall = 1'b1; i_stall = 1'b1; flush_excM = 1'b1; div_startE = 1'b1;
        tick(); tick();
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", outs, P_NONE);
        end
        tick();
        idle_inputs();
        resetn = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL reset_release_idle: got %b want %b", outs, P_NONE);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_tests++;
        if ({perf_load_use, perf_div_stall, perf_mem_stall} !== 96'd0) begin
            n_fail++; $display("FAIL reset_perf: got %h/%h/%h want 0", perf_load_use, perf_div_stall, perf_mem_stall);
        end
`endif
        tick();
    endtask

    task automatic test_load_use();
        set_lw_hit();
        #1;
        n_tests++;
        if (outs !== P_LU) begin
            n_fail++; $display("FAIL lu_rs: got %b want %b", outs, P_LU);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL lu_next: got %b want %b", outs, P_NONE);
        end
        tick();
        set_lw_hit(); rsD = 5'd1; rtD = 5'd8;
        #1;
        n_tests++;
        if (outs !== P_LU) begin
            n_fail++; $display("FAIL lu_rt: got %b want %b", outs, P_LU);
        end
        tick();
        set_lw_hit(); writeregE = 5'd0; rsD = 5'd0;
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL lu_zero_reg: got %b want %b", outs, P_NONE);
        end
        tick();
        set_lw_hit(); memtoregE = 1'b0;
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL lu_not_load: got %b want %b", outs, P_NONE);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mispredict();
        branch_mispredE = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_MISP) begin
            n_fail++; $display("FAIL misp_alone: got %b want %b", outs, P_MISP);
        end
        tick();
        set_lw_hit(); branch_mispredE = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_MISP) begin
            n_fail++; $display("FAIL misp_over_lu: got %b want %b", outs, P_MISP);
        end
        tick();
        idle_inputs(); branch_mispredE = 1'b1; i_stall = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_IST) begin
            n_fail++; $display("FAIL misp_with_istall: got %b want %b", outs, P_IST);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_cache_stalls();
        i_stall = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_IST) begin
            n_fail++; $display("FAIL istall_alone: got %b want %b", outs, P_IST);
        end
        tick();
        d_stall = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_DST) begin
            n_fail++; $display("FAIL istall_dstall: got %b want %b", outs, P_DST);
        end
        tick();
        idle_inputs(); set_lw_hit(); d_stall = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_DST) begin
            n_fail++; $display("FAIL dstall_over_lu: got %b want %b", outs, P_DST);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_divide(input bit with_dstall);
        logic [10:0] exp;
        int busy_cnt;
        busy_cnt = 0;
        div_startE = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL div_accept_cycle: got %b want %b", outs, P_NONE);
        end
        tick();
        for (int i = 0; i < 40; i++) begin
            div_startE = (i == 10);
            i_stall    = (i == 5);
            d_stall    = with_dstall && (i >= 3) && (i <= 5);
            #1;
            if (i >= 36)                 exp = P_NONE;
            else if (d_stall)            exp = P_DSTB;
            else                         exp = P_DIV;
            if (div_busy === 1'b1 && stallE === (d_stall ? 1'b1 : 1'b1)) busy_cnt++;
            n_tests++;
            if (outs !== exp) begin
                n_fail++; $display("FAIL div_cycle_%0d (dstall=%0d): got %b want %b", i, with_dstall, outs, exp);
            end
            tick();
        end
        n_tests++;
        if (busy_cnt != 36) begin
            n_fail++; $display("FAIL div_busy_length: got %0d want 36", busy_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_exception();
        flush_excM = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_EXC) begin
            n_fail++; $display("FAIL exc_immediate: got %b want %b", outs, P_EXC);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL exc_immediate_after: got %b want %b", outs, P_NONE);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            flush_excM = (i == 0);
            d_stall    = 1'b1;
            #1;
            n_tests++;
            if (outs !== P_DST) begin
                n_fail++; $display("FAIL exc_pend_hold_%0d: got %b want %b", i, outs, P_DST);
            end
            tick();
        end
        idle_inputs();
        #1;
        n_tests++;
        if (outs !== P_EXC) begin
            n_fail++; $display("FAIL exc_pend_release: got %b want %b", outs, P_EXC);
        end
        tick();
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL exc_pend_done: got %b want %b", outs, P_NONE);
        end
        tick();
        set_lw_hit(); i_stall = 1'b1; flush_excM = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_EXC) begin
            n_fail++; $display("FAIL exc_over_lu_istall: got %b want %b", outs, P_EXC);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_exc_abandons_div();
        div_startE = 1'b1;
        tick();
        div_startE = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        flush_excM = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_EXCB) begin
            n_fail++; $display("FAIL exc_kill_div: got %b want %b", outs, P_EXCB);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL exc_kill_div_after: got %b want %b", outs, P_NONE);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        div_startE = 1'b1;
        tick();
        div_startE = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        #1;
        n_tests++;
        if (outs !== P_DIV) begin
            n_fail++; $display("FAIL rst_div_before: got %b want %b", outs, P_DIV);
        end
        resetn = 1'b0;
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL rst_div_during: got %b want %b", outs, P_NONE);
        end
        tick();
        resetn = 1'b1;
        #1;
        n_tests++;
        if (outs !== P_NONE) begin
            n_fail++; $display("FAIL rst_div_after: got %b want %b", outs, P_NONE);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_tests++;
        if ({perf_load_use, perf_div_stall, perf_mem_stall} !== 96'd0) begin
            n_fail++; $display("FAIL rst_div_perf: got %h/%h/%h want 0", perf_load_use, perf_div_stall, perf_mem_stall);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mispredict();
        test_cache_stalls();
        test_divide(1'b0);
        test_divide(1'b1);
        test_exception();
        test_exc_abandons_div();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
